// File: rtl/truth_table_scanner_pkg.sv
// Shared types and width helpers for the truth table scanner.
package truth_table_scanner_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, DONE} state_t;

    function automatic int tbl_w(input int n);
        return 1 << n;
    endfunction

    function automatic int cnt_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Settle down-counter: loaded with SETTLE while driving, decremented while waiting.
module tts_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int TW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TW'(SETTLE);
        end else if (en && cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    // Flags on the last wait cycle, so the count reaches 0 as the FSM leaves WAIT.
    assign expired = (cnt <= TW'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// Self-sequencing sweep of an N-input combinational function against a reference table.
// Optional stop-at-first-mismatch mode with fail_idx output: TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int N      = 5,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [tbl_w(N)-1:0]   ref_table,
    output logic [N-1:0]          dut_in,
    input  logic                  dut_f,
    output logic                  busy,
    output logic                  done,
    output logic [tbl_w(N)-1:0]   table_out,
    output logic [tbl_w(N)-1:0]   err_mask,
    output logic [cnt_w(N)-1:0]   err_cnt,
    output logic                  pass,
`ifdef TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN
    output logic [N-1:0]          fail_idx,
`endif
    output state_t                state_dbg
);

    localparam int TBL_W = tbl_w(N);
    localparam int CNT_W = cnt_w(N);

    state_t             state;
    logic [N-1:0]       idx;
    logic [TBL_W-1:0]   ref_q;
    logic               mism;
    logic               last;
    logic               expired;
    logic [CNT_W-1:0]   cnt_nxt;

    assign mism      = dut_f ^ ref_q[idx];
    assign cnt_nxt   = err_cnt + CNT_W'(mism);
    assign last      = (idx == N'(TBL_W - 1));
    assign state_dbg = state;

    tts_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (state == DRIVE),
        .en      (state == WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            ref_q     <= '0;
            dut_in    <= '0;
            table_out <= '0;
            err_mask  <= '0;
            err_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN
            fail_idx  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ref_q     <= ref_table;
                        idx       <= '0;
                        table_out <= '0;
                        err_mask  <= '0;
                        err_cnt   <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
`ifdef TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN
                        fail_idx  <= '0;
`endif
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    dut_in <= idx;
                    state  <= (SETTLE == 0) ? SAMPLE : WAIT;
                end
                WAIT: begin
                    if (expired) state <= SAMPLE;
                end
                SAMPLE: begin
                    table_out[idx] <= dut_f;
                    err_mask[idx]  <= mism;
                    err_cnt        <= cnt_nxt;
                    // Terminal test precedes the increment, so idx never wraps.
`ifdef TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN
                    if (mism || last) begin
                        if (mism) fail_idx <= idx;
`else
                    if (last) begin
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (cnt_nxt == '0);
                        state <= DONE;
                    end else begin
                        idx   <= idx + N'(1);
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner; exercises fail_idx when TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN is defined.
module tb_truth_table_scanner;
    import truth_table_scanner_pkg::*;

    localparam int N      = 5;
    localparam int SETTLE = 1;
    localparam int TBL_W  = 32;
    localparam int CNT_W  = 6;
    localparam int EXP_W  = 2 * TBL_W + CNT_W + 1;
    localparam logic [31:0] REF_A = 32'h52263ECD;

    logic               clk;
    logic               rst;
    logic               start;
    logic [TBL_W-1:0]   ref_table;
    logic [N-1:0]       dut_in;
    logic               dut_f;
    logic               busy;
    logic               done;
    logic [TBL_W-1:0]   table_out;
    logic [TBL_W-1:0]   err_mask;
    logic [CNT_W-1:0]   err_cnt;
    logic               pass;
    state_t             state_dbg;
`ifdef TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN
    logic [N-1:0]       fail_idx;
`endif

    logic [TBL_W-1:0]   model_tbl;
    logic [EXP_W-1:0]   exp_q[$];
    int                 exp_cyc_q[$];
    int                 n_checks;
    int                 n_fail;

    truth_table_scanner #(.N(N), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_table (ref_table),
        .dut_in    (dut_in),
        .dut_f     (dut_f),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .err_mask  (err_mask),
        .err_cnt   (err_cnt),
        .pass      (pass),
`ifdef TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN
        .fail_idx  (fail_idx),
`endif
        .state_dbg (state_dbg)
    );

    // Function under test: a lookup into the table the current test chooses.
    assign dut_f = model_tbl[dut_in];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_expected(input logic [31:0] m, input logic [31:0] r);
        logic [31:0] mask;
        logic [31:0] tbl;
        int          cyc;
        mask = m ^ r;
        tbl  = m;
        cyc  = TBL_W * (2 + SETTLE);
`ifdef TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN
        for (int i = 0; i < TBL_W; i++) begin
            if (mask[i]) begin
                mask = 32'(1) << i;
                tbl  = m & ((32'(2) << i) - 32'(1));
                cyc  = (i + 1) * (2 + SETTLE);
                break;
            end
        end
`endif
        exp_q.push_back({tbl, mask, CNT_W'($countones(mask)), (mask == 32'h0)});
        exp_cyc_q.push_back(cyc);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_sweep(input logic [31:0] m, input logic [31:0] r,
                             output logic [EXP_W-1:0] obs, output int cyc);
        model_tbl = m;
        ref_table = r;
        push_expected(m, r);
        do_start();
        wait_done(cyc);
        obs = {table_out, err_mask, err_cnt, pass};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, pass, dut_in, table_out, err_mask, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b dut_in=%h tbl=%h mask=%h cnt=%0d, expected all zero",
                     busy, done, pass, dut_in, table_out, err_mask, err_cnt);
        end
        n_checks++;
        if (state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
        end
    endtask

    task automatic test_sweep(input string name, input logic [31:0] m, input logic [31:0] r);
        logic [EXP_W-1:0] obs;
        logic [EXP_W-1:0] exp;
        int               cyc;
        int               exp_cyc;
        run_sweep(m, r, obs, cyc);
        exp     = exp_q.pop_front();
        exp_cyc = exp_cyc_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s_result: got {tbl,mask,cnt,pass}=%h expected %h", name, obs, exp);
        end
        n_checks++;
        if (cyc !== exp_cyc) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc, exp_cyc);
        end
        n_checks++;
        if (busy !== 1'b0 || state_dbg !== DONE) begin
            n_fail++;
            $display("FAIL %s_done_state: got busy=%b state=%0d expected busy=0 state=%0d",
                     name, busy, state_dbg, DONE);
        end
    endtask

    task automatic test_hold_dut_in();
        n_checks++;
        if (dut_in !== 5'd31) begin
            n_fail++;
            $display("FAIL hold_dut_in: got %0d expected 31", dut_in);
        end
    endtask

    task automatic test_back_to_back();
        logic [EXP_W-1:0] obs;
        logic [EXP_W-1:0] exp;
        int               cyc;
        int               exp_cyc;
        model_tbl = 32'h0F0F_AAAA;
        ref_table = 32'h0F0F_AAAB;
        push_expected(model_tbl, ref_table);
        do_start();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: got done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        wait_done(cyc);
        obs     = {table_out, err_mask, err_cnt, pass};
        exp     = exp_q.pop_front();
        exp_cyc = exp_cyc_q.pop_front();
        n_checks++;
        if (obs !== exp || cyc !== exp_cyc) begin
            n_fail++;
            $display("FAIL b2b_result: got %h in %0d cycles expected %h in %0d", obs, cyc, exp, exp_cyc);
        end
    endtask

    task automatic test_mid_reset();
        model_tbl = REF_A;
        ref_table = REF_A ^ 32'hFFFF_FFFF;
        do_start();
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (state_dbg !== IDLE || busy !== 1'b0 || err_cnt !== '0 || done !== 1'b0 ||
            table_out !== '0 || err_mask !== '0 || dut_in !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got state=%0d busy=%b cnt=%0d done=%b tbl=%h mask=%h dut_in=%0d expected idle zeros",
                     state_dbg, busy, err_cnt, done, table_out, err_mask, dut_in);
        end
        test_sweep("after_reset", REF_A, REF_A);
    endtask

    task automatic test_busy_start();
        logic [EXP_W-1:0] obs;
        logic [EXP_W-1:0] exp;
        int               cyc;
        int               exp_cyc;
        model_tbl = REF_A ^ 32'hF000_0000;
        ref_table = REF_A;
        push_expected(model_tbl, REF_A);
        do_start();
        repeat (10) @(negedge clk);
        ref_table = ~REF_A;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_done(cyc);
        cyc     = cyc + 11;
        obs     = {table_out, err_mask, err_cnt, pass};
        exp     = exp_q.pop_front();
        exp_cyc = exp_cyc_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL busy_start_result: got %h expected %h", obs, exp);
        end
        n_checks++;
        if (cyc !== exp_cyc) begin
            n_fail++;
            $display("FAIL busy_start_latency: got %0d cycles expected %0d", cyc, exp_cyc);
        end
    endtask

    task automatic test_random();
        logic [31:0] m;
        for (int k = 0; k < 3; k++) begin
            m = $urandom;
            test_sweep("random", m, m ^ ($urandom & $urandom & $urandom));
        end
    endtask

`ifdef TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN
    task automatic test_stop_on_err();
        test_sweep("stop_at_7", REF_A ^ 32'h0000_0080, REF_A);
        n_checks++;
        if (fail_idx !== 5'd7 || err_mask !== 32'h0000_0080 || err_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL stop_fail_idx: got idx=%0d mask=%h cnt=%0d expected idx=7 mask=00000080 cnt=1",
                     fail_idx, err_mask, err_cnt);
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        ref_table = '0;
        model_tbl = '0;
        test_reset();
        test_sweep("correct", REF_A, REF_A);
        test_hold_dut_in();
        test_sweep("invert0", REF_A ^ 32'h0000_0001, REF_A);
        test_sweep("const0", 32'h0, REF_A);
        test_back_to_back();
        test_mid_reset();
        test_busy_start();
        test_random();
`ifdef TRUTH_TABLE_SCANNER_STOP_ON_ERR_EN
        test_stop_on_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
